// File: rtl/img_window_fetch.sv
// Fetches a stored image from ROM into a fixed window of the active video area.
// Debounced next/prev buttons select the image; changes take effect at frame start.
module img_window_fetch #(
  parameter int          NUM_IMG   = 2,
  parameter int          IMG_W     = 320,
  parameter int          IMG_H     = 240,
  parameter int          IMG_X     = 160,
  parameter int          IMG_Y     = 120,
  parameter int          ROM_LAT   = 1,
  parameter int          DB_CYCLES = 250000,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  localparam int         ADDR_W    = $clog2(NUM_IMG * IMG_W * IMG_H),
  localparam int         SEL_W     = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [10:0]       hor_pos,
  input  logic [10:0]       ver_pos,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic [11:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [SEL_W-1:0]  img_sel,
  output logic              switch_pending,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b
);

  localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DB_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IMG_SIZE = ADDR_W'(IMG_W * IMG_H);
  localparam logic [11:0]       WX0      = 12'(IMG_X);
  localparam logic [11:0]       WX1      = 12'(IMG_X + IMG_W - 1);
  localparam logic [11:0]       WY0      = 12'(IMG_Y);
  localparam logic [11:0]       WY1      = 12'(IMG_Y + IMG_H - 1);
  localparam logic [0:0]        S_IDLE   = 1'b0;
  localparam logic [0:0]        S_PEND   = 1'b1;

  // Bit 0 carries btn_next, bit 1 carries btn_prev through the debounce path.
  logic [1:0]        sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d, rise;
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];
  logic [0:0]        state_q, state_d;
  logic [SEL_W-1:0]  img_sel_q, img_sel_d, tgt_q, tgt_d, tgt_base, tgt_new;
  logic              req_next, req_prev, req_any, frame_start, in_win;
  logic              frame_seen_q, frame_seen_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT-1:0] win_pipe_q, win_pipe_d, vld_pipe_q, vld_pipe_d;
  logic [11:0]       color_q, color_d;

  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] s, input logic fwd);
    if (fwd) return (s == SEL_W'(NUM_IMG - 1)) ? '0 : s + 1'b1;
    else     return (s == '0) ? SEL_W'(NUM_IMG - 1) : s - 1'b1;
  endfunction

  always_comb begin
    sync1_d = {btn_prev, btn_next};
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) db_d[i]  = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise     = db_d & ~db_q;
    req_next = rise[0] & ~rise[1];
    req_prev = rise[1] & ~rise[0];
    req_any  = req_next | req_prev;
  end

  // Presses made while pending accumulate onto the stored target.
  always_comb begin
    frame_start = !valid && (hor_pos == 11'd0) && (ver_pos == 11'd0);
    tgt_base    = (state_q == S_PEND) ? tgt_q : img_sel_q;
    tgt_new     = sel_step(tgt_base, req_next);
    state_d     = state_q;
    tgt_d       = tgt_q;
    img_sel_d   = img_sel_q;
    if (frame_start && (state_q == S_PEND)) begin
      img_sel_d = req_any ? tgt_new : tgt_q;
      state_d   = S_IDLE;
    end else if (req_any) begin
      tgt_d   = tgt_new;
      state_d = S_PEND;
    end
  end

  // Window pixels are fetched only once a frame start has been seen since reset.
  always_comb begin
    frame_seen_d = frame_seen_q | frame_start;
    in_win = frame_seen_q && valid &&
             ({1'b0, hor_pos} >= WX0) && ({1'b0, hor_pos} <= WX1) &&
             ({1'b0, ver_pos} >= WY0) && ({1'b0, ver_pos} <= WY1);
    rom_addr_d = rom_addr_q;
    if (frame_start)  rom_addr_d = ADDR_W'(img_sel_d) * IMG_SIZE;
    else if (in_win)  rom_addr_d = rom_addr_q + 1'b1;
    win_pipe_d = (win_pipe_q << 1) | ROM_LAT'(in_win);
    vld_pipe_d = (vld_pipe_q << 1) | ROM_LAT'(valid);
    if (win_pipe_q[ROM_LAT-1])      color_d = rom_data;
    else if (vld_pipe_q[ROM_LAT-1]) color_d = BG_COLOR;
    else                            color_d = 12'h000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      state_q      <= S_IDLE;
      tgt_q        <= '0;
      img_sel_q    <= '0;
      frame_seen_q <= 1'b0;
      rom_addr_q   <= '0;
      win_pipe_q   <= '0;
      vld_pipe_q   <= '0;
      color_q      <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_q         <= db_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      img_sel_q    <= img_sel_d;
      frame_seen_q <= frame_seen_d;
      rom_addr_q   <= rom_addr_d;
      win_pipe_q   <= win_pipe_d;
      vld_pipe_q   <= vld_pipe_d;
      color_q      <= color_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign img_sel        = img_sel_q;
  assign switch_pending = (state_q == S_PEND);
  assign vga_r          = color_q[11:8];
  assign vga_g          = color_q[7:4];
  assign vga_b          = color_q[3:0];

endmodule

// File: doc/img_window_fetch.md
IMG_WINDOW_FETCH -- requirements
Module: img_window_fetch

Interface
REQ-001 SHALL have parameter NUM_IMG, default 2: number of images stored back-to-back in ROM, minimum 1.
REQ-002 SHALL have parameter IMG_W, default 320: image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 240: image height in lines.
REQ-004 SHALL have parameter IMG_X, default 160: first active column of the window.
REQ-005 SHALL have parameter IMG_Y, default 120: first active line of the window.
REQ-006 SHALL have parameter ROM_LAT, default 1: ROM read latency in clk cycles, 1..4.
REQ-007 SHALL have parameter DB_CYCLES, default 250000: button debounce stable-time in clk cycles.
REQ-008 SHALL have parameter BG_COLOR, default 12'h000: colour inside the active area but outside the window.
REQ-009 SHALL have local widths ADDR_W = clog2(NUM_IMG*IMG_W*IMG_H) and SEL_W = max(1, clog2(NUM_IMG)).
REQ-010 SHALL have port clk, input, 1 bit: pixel clock; every register uses its rising edge.
REQ-011 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-012 SHALL have port valid, input, 1 bit: the timing generator is in the active area.
REQ-013 SHALL have ports hor_pos and ver_pos, input, 11 bits each: current column and line from the timing generator.
REQ-014 SHALL have ports btn_next and btn_prev, input, 1 bit each: raw, asynchronous push buttons, active-high.
REQ-015 SHALL have port rom_data, input, 12 bits: ROM pixel in {R[11:8], G[7:4], B[3:0]} format.
REQ-016 SHALL have port rom_addr, output, ADDR_W bits: ROM read address.
REQ-017 SHALL have port img_sel, output, SEL_W bits: image currently displayed.
REQ-018 SHALL have port switch_pending, output, 1 bit: an image change is waiting for the frame boundary.
REQ-019 SHALL have ports vga_r, vga_g and vga_b, output, 4 bits each: pixel colour.

Function
REQ-020 SHALL pass each button through a 2-flop synchroniser, then a counter; the debounced level updates only after the input holds a new value for DB_CYCLES consecutive cycles.
REQ-021 SHALL generate a one-cycle request pulse on each debounced 0->1 edge; no request on release.
REQ-022 SHALL ignore next and prev requests that arrive in the same cycle.
REQ-023 SHALL compute the target image with wrap-around: next from NUM_IMG-1 goes to 0, prev from 0 goes to NUM_IMG-1; with NUM_IMG=1 the target always equals img_sel.
REQ-024 SHALL run a 2-state FSM. In IDLE, a request stores the target and moves to PENDING. In PENDING, a new request recomputes the target from the stored target (so presses accumulate). At frame start, img_sel takes the target and the FSM returns to IDLE.
REQ-025 SHALL define frame start as the single cycle where valid=0, ver_pos=0 and hor_pos=0.
REQ-026 SHALL assert switch_pending exactly while the FSM is in PENDING.
REQ-027 SHALL define the window as valid=1, IMG_X <= hor_pos <= IMG_X+IMG_W-1 and IMG_Y <= ver_pos <= IMG_Y+IMG_H-1, using 12-bit compares with no overflow.
REQ-028 SHALL load rom_addr with base = sel*IMG_W*IMG_H at frame start, where sel is the value img_sel takes in that same cycle.
REQ-029 SHALL advance rom_addr by 1 on every in-window cycle, and hold it otherwise.
REQ-030 SHALL make rom_addr equal base + (ver_pos-IMG_Y)*IMG_W + (hor_pos-IMG_X) during each in-window cycle.
REQ-031 SHALL delay the in-window flag and valid by ROM_LAT cycles to align them with rom_data.
REQ-032 SHALL register the colour outputs, so a pixel at timing cycle t appears on vga_* at t+ROM_LAT+1.
REQ-033 SHALL select the output colour by the delayed flags: delayed window gives rom_data; delayed valid outside the window gives BG_COLOR; blanking gives 12'h000.

Reset
REQ-034 SHALL, while rst_n=0, force img_sel=0, rom_addr=0, switch_pending=0, vga_r/g/b=0, FSM=IDLE, debounced levels=0, debounce counters=0 and delay pipelines=0.
REQ-035 SHALL, when reset is asserted mid-frame or while PENDING, discard the pending target; after release, output ROM pixels only from the next frame start.

Verification
REQ-036 Scenario: reset, then one full 640x480 frame with defaults -> first window pixel at (160,120) reads rom_addr 0; last pixel at (479,359) reads 76799; all other active pixels show 000; blanking shows 000.
REQ-037 Scenario: btn_next high for DB_CYCLES+4 cycles mid-frame -> switch_pending=1, img_sel stays 0 until frame start; then img_sel=1 and the first window address is 76800.
REQ-038 Scenario: img_sel=1, btn_next pressed -> wraps to 0; with img_sel=0, btn_prev pressed -> 1.
REQ-039 Scenario: btn_next glitch of DB_CYCLES-1 cycles, and btn_next with btn_prev rising together -> no request, switch_pending stays 0.
REQ-040 Scenario: ROM_LAT=3 model with rom_data=addr[11:0] -> vga_* at t+4 equals the address issued at t for every window pixel.
REQ-041 Scenario: rst_n pulsed low while PENDING at line 200 -> all outputs 0 immediately; img_sel=0 after release; the next frame's first address is 0.
